// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, function
// codes, ALU control codes, ALU-op selectors and the FSM state encoding.
package mips_pkg;

  // Primary opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instruction bits [5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU-op selector from the main FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Controller states; the numeric values are visible on the debug port
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the FSM's ALU-op selector and the R-type funct field
// to a 3-bit ALU control code; flags unsupported funct values.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol,
  output logic       funct_illegal
);

  // Combinational decode; unknown funct falls back to add
  always_comb begin
    alucontrol    = ALU_ADD;
    funct_illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: begin
            alucontrol    = ALU_ADD;
            funct_illegal = 1'b1;
          end
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS controller: Moore FSM sequencing fetch, decode and the
// per-instruction execution steps, driving datapath strobes and mux selects.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  localparam state_t TRAP_STATE = ILLEGAL_TRAP ? S_HALT : S_FETCH;

  state_t     r_state;
  state_t     w_next;

  logic       w_pcen;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_illegal;
  logic       w_use_alu;
  logic [1:0] w_aluop;
  logic [2:0] w_dec_alucontrol;
  logic       w_funct_illegal;

  alu_decoder u_alu_decoder (
    .funct        (funct),
    .aluop        (w_aluop),
    .alucontrol   (w_dec_alucontrol),
    .funct_illegal(w_funct_illegal)
  );

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state and per-state outputs; everything unlisted stays 0
  always_comb begin
    w_next     = S_FETCH;
    w_pcen     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    w_use_alu  = 1'b0;
    w_aluop    = ALUOP_ADD;
    iord       = 1'b0;
    alusrca    = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_use_alu = 1'b1;
        w_irwrite = 1'b1;
        w_pcen    = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        alusrcb   = 2'b11;
        w_use_alu = 1'b1;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_illegal = 1'b1;
            w_next    = TRAP_STATE;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        w_use_alu = 1'b1;
        if (op == OP_LW)      w_next = S_MEMRD;
        else if (op == OP_SW) w_next = S_MEMWR;
        else                  w_next = S_FETCH;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca   = 1'b1;
        w_aluop   = ALUOP_FUNCT;
        w_use_alu = 1'b1;
        if (w_funct_illegal) begin
          w_illegal = 1'b1;
          w_next    = TRAP_STATE;
        end else begin
          w_next = S_ALUWB;
        end
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alusrca   = 1'b1;
        w_aluop   = ALUOP_SUB;
        w_use_alu = 1'b1;
        pcsrc     = 2'b01;
        w_pcen    = zero;
        w_next    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        w_use_alu = 1'b1;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        pcsrc  = 2'b10;
        w_pcen = 1'b1;
        w_next = S_FETCH;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are masked while reset is asserted so nothing commits mid-reset
  assign pcen       = reset & w_pcen;
  assign memwrite   = reset & w_memwrite;
  assign irwrite    = reset & w_irwrite;
  assign regwrite   = reset & w_regwrite;
  assign illegal    = reset & w_illegal;
  assign alucontrol = w_use_alu ? w_dec_alucontrol : '0;
  assign state      = r_state;

endmodule
